// File: rtl/risc_pkg.sv
// risc_pkg: shared definitions for the RISC controller slice.
//   state_t      - controller FSM states (S_TRAP only with RISC_ILLEGAL_TRAP_EN)
//   OPC_* / OP_* - instruction opcode and sub-op field values
//   ALU_*        - datapath ALU operation selects
//   SH_*         - datapath shifter selects
// Macro: RISC_ILLEGAL_TRAP_EN adds the sticky TRAP state.
package risc_pkg;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_EXEC   = 3'd4,
        S_WR_REG = 3'd5,
        S_WR_IMM = 3'd6
`ifdef RISC_ILLEGAL_TRAP_EN
        ,
        S_TRAP   = 3'd7
`endif
    } state_t;

    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [2:0] OPC_MOV    = 3'b110;

    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_AND    = 3'b010;
    localparam logic [2:0] ALU_NOTB   = 3'b011;

    localparam logic [2:0] SH_NONE    = 3'b000;
    localparam logic [2:0] SH_LSL     = 3'b001;
    localparam logic [2:0] SH_LSR     = 3'b010;
    localparam logic [2:0] SH_ASR     = 3'b011;

endpackage

// File: rtl/instr_dec.sv
// instr_dec: purely combinational instruction-word decoder.
//   ir       in  16      instruction register contents
//   opcode   out 3       ir[15:13]
//   op       out 2       ir[12:11]
//   rn/rd/rm out 3 each  register fields ir[10:8] / ir[7:5] / ir[2:0]
//   sh       out 2       shift field ir[4:3]
//   imm_out  out DATA_W  sign-extended ir[7:0]
//   illegal  out 1       opcode/op combination not supported
module instr_dec
    import risc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [15:0]       ir,
    output logic [2:0]        opcode,
    output logic [1:0]        op,
    output logic [2:0]        rn,
    output logic [2:0]        rd,
    output logic [1:0]        sh,
    output logic [2:0]        rm,
    output logic [DATA_W-1:0] imm_out,
    output logic              illegal
);

    always_comb begin
        opcode  = ir[15:13];
        op      = ir[12:11];
        rn      = ir[10:8];
        rd      = ir[7:5];
        sh      = ir[4:3];
        rm      = ir[2:0];
        imm_out = DATA_W'($signed(ir[7:0]));
        illegal = 1'b1;
        if (opcode == OPC_ALU) begin
            illegal = 1'b0;
        end else if (opcode == OPC_MOV) begin
            illegal = !((op == OP_MOV_REG) || (op == OP_MOV_IMM));
        end
    end

endmodule

// File: rtl/risc_controller.sv
// risc_controller: Moore FSM sequencing a simple datapath through
// register reads, ALU execution and register write-back.
//   clk, reset_n                   clock, async active-low reset
//   s, load, in[15:0]              start, IR load enable, instruction word
//   w                              high only while idle in WAIT
//   readnum, writenum              register-file indices (0 when unused)
//   ALUop, shift                   datapath operation selects
//   write, loada..loads            datapath strobes
//   asel, bsel, vsel               datapath mux selects
//   imm_out[DATA_W-1:0]            sign-extended imm8 from the IR
//   err                            illegal-instruction flag
// Macro: RISC_ILLEGAL_TRAP_EN - illegal instructions park the FSM in TRAP
//        (err=1) until reset; otherwise they return silently to WAIT.
module risc_controller
    import risc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s,
    input  logic              load,
    input  logic [15:0]       in,
    output logic              w,
    output logic [2:0]        readnum,
    output logic [2:0]        writenum,
    output logic [2:0]        ALUop,
    output logic [2:0]        shift,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic              vsel,
    output logic [DATA_W-1:0] imm_out,
    output logic              err
);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] ir_q;

    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [1:0]  sh;
    logic [2:0]  rm;
    logic        illegal;

    logic        is_mov_imm;
    logic        is_mov_reg;
    logic        is_mvn;
    logic        is_cmp;

    instr_dec #(
        .DATA_W (DATA_W)
    ) u_dec (
        .ir      (ir_q),
        .opcode  (opcode),
        .op      (op),
        .rn      (rn),
        .rd      (rd),
        .sh      (sh),
        .rm      (rm),
        .imm_out (imm_out),
        .illegal (illegal)
    );

    always_comb begin
        is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
        is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
        is_mvn     = (opcode == OPC_ALU) && (op == OP_MVN);
        is_cmp     = (opcode == OPC_ALU) && (op == OP_CMP);
    end

    // Reset clears the state register directly, so an in-flight write-back
    // state is abandoned before its strobe can reach the register file.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_WAIT) && load) begin
                ir_q <= in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:   if (s) state_d = S_DECODE;
            S_DECODE: begin
                if (illegal) begin
`ifdef RISC_ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    state_d = S_WAIT;
`endif
                end else if (is_mov_imm) begin
                    state_d = S_WR_IMM;
                end else if (is_mov_reg || is_mvn) begin
                    // Single-operand instructions only need the B operand.
                    state_d = S_GET_B;
                end else begin
                    state_d = S_GET_A;
                end
            end
            S_GET_A:  state_d = S_GET_B;
            S_GET_B:  state_d = S_EXEC;
            S_EXEC:   state_d = is_cmp ? S_WAIT : S_WR_REG;
            S_WR_REG: state_d = S_WAIT;
            S_WR_IMM: state_d = S_WAIT;
`ifdef RISC_ILLEGAL_TRAP_EN
            S_TRAP:   state_d = S_TRAP;
`endif
            default:  state_d = S_WAIT;
        endcase
    end

    always_comb begin
        w        = 1'b0;
        readnum  = '0;
        writenum = '0;
        ALUop    = ALU_ADD;
        shift    = SH_NONE;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = 1'b0;
        case (state_q)
            S_WAIT:   w = 1'b1;
            S_GET_A: begin
                loada   = 1'b1;
                readnum = rn;
            end
            S_GET_B: begin
                loadb   = 1'b1;
                readnum = rm;
            end
            S_EXEC: begin
                // MOV reg passes B through the adder with A forced to zero.
                ALUop = is_mov_reg ? ALU_ADD : {1'b0, op};
                shift = {1'b0, sh};
                asel  = is_mov_reg;
                loadc = 1'b1;
                loads = is_cmp;
            end
            S_WR_REG: begin
                write    = 1'b1;
                writenum = rd;
            end
            S_WR_IMM: begin
                write    = 1'b1;
                vsel     = 1'b1;
                writenum = rn;
            end
            default: ;
        endcase
    end

`ifdef RISC_ILLEGAL_TRAP_EN
    always_comb err = (state_q == S_TRAP);
`else
    always_comb err = 1'b0;
`endif

endmodule

// File: tb/tb_risc_controller.sv
// tb_risc_controller: directed and randomized checks of risc_controller
// against a per-instruction expected-output schedule built from the
// instruction-set rules.
module tb_risc_controller;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              s;
    logic              load;
    logic [15:0]       in;
    logic              w;
    logic [2:0]        readnum;
    logic [2:0]        writenum;
    logic [2:0]        ALUop;
    logic [2:0]        shift;
    logic              write;
    logic              loada;
    logic              loadb;
    logic              loadc;
    logic              loads;
    logic              asel;
    logic              bsel;
    logic              vsel;
    logic [DATA_W-1:0] imm_out;
    logic              err;

    int n_pass   = 0;
    int n_checks = 0;

    typedef struct packed {
        logic       w;
        logic       err;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic [2:0] aluop;
        logic [2:0] shift;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic       vsel;
    } outs_t;

    outs_t exp_q[$];

    risc_controller #(
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .s        (s),
        .load     (load),
        .in       (in),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .ALUop    (ALUop),
        .shift    (shift),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .vsel     (vsel),
        .imm_out  (imm_out),
        .err      (err)
    );

    always #5 clk = ~clk;

    function automatic outs_t observed();
        outs_t o;
        o.w = w;          o.err = err;
        o.readnum = readnum;  o.writenum = writenum;
        o.aluop = ALUop;  o.shift = shift;
        o.write = write;  o.loada = loada;  o.loadb = loadb;
        o.loadc = loadc;  o.loads = loads;
        o.asel = asel;    o.bsel = bsel;    o.vsel = vsel;
        return o;
    endfunction

    function automatic logic [15:0] sext8(input logic [7:0] b);
        int v;
        v = int'(b);
        if (v >= 128) v = v - 256;
        return 16'(v);
    endfunction

    function automatic bit is_legal(input logic [15:0] instr);
        int opc, op;
        opc = int'(instr[15:13]);
        op  = int'(instr[12:11]);
        return (opc == 5) || (opc == 6 && (op == 0 || op == 2));
    endfunction

    // Expected outputs for every cycle from DECODE up to (not incl.) WAIT.
    function automatic void model(input logic [15:0] instr);
        int         opc, op;
        logic [2:0] rn, rd, rm, sh3;
        outs_t      o;
        opc = int'(instr[15:13]);
        op  = int'(instr[12:11]);
        rn  = instr[10:8];
        rd  = instr[7:5];
        rm  = instr[2:0];
        sh3 = {1'b0, instr[4:3]};
        exp_q.delete();
        exp_q.push_back('0);
        if (opc == 6 && op == 2) begin
            o = '0; o.write = 1'b1; o.vsel = 1'b1; o.writenum = rn;
            exp_q.push_back(o);
        end else if (opc == 6 && op == 0) begin
            o = '0; o.loadb = 1'b1; o.readnum = rm;
            exp_q.push_back(o);
            o = '0; o.aluop = 3'd0; o.shift = sh3; o.asel = 1'b1; o.loadc = 1'b1;
            exp_q.push_back(o);
            o = '0; o.write = 1'b1; o.writenum = rd;
            exp_q.push_back(o);
        end else if (opc == 5) begin
            if (op != 3) begin
                o = '0; o.loada = 1'b1; o.readnum = rn;
                exp_q.push_back(o);
            end
            o = '0; o.loadb = 1'b1; o.readnum = rm;
            exp_q.push_back(o);
            o = '0; o.aluop = 3'(op); o.shift = sh3; o.loadc = 1'b1;
            o.loads = (op == 1);
            exp_q.push_back(o);
            if (op != 1) begin
                o = '0; o.write = 1'b1; o.writenum = rd;
                exp_q.push_back(o);
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Called at a negedge with the DUT in WAIT. reset_at >= 0 pulls reset
    // after checking that schedule index.
    task automatic run_instr(input logic [15:0] instr, input bit noise,
                             input int reset_at, input string tag);
        outs_t       waitv;
        logic [15:0] imm_exp;
        int          writes, exp_writes;
        model(instr);
        waitv = '0;
        waitv.w = 1'b1;
        imm_exp = sext8(instr[7:0]);
        exp_writes = 0;
        foreach (exp_q[k]) if (exp_q[k].write) exp_writes++;
        writes = 0;
        in = instr; load = 1'b1; s = 1'b1;
        @(negedge clk);
        load = 1'b0; s = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s outs c%0d", tag, i), 32'(observed()), 32'(exp_q[i]));
            chk($sformatf("%s imm c%0d", tag, i), 32'(imm_out), 32'(imm_exp));
            if (write) writes++;
            if (i == reset_at) begin
                reset_n = 1'b0;
                #1;
                chk($sformatf("%s rst async", tag), 32'(observed()), 32'(waitv));
                chk($sformatf("%s rst ir", tag), 32'(imm_out), 32'h0);
                s = 1'b0; load = 1'b0;
                #2 reset_n = 1'b1;
                @(negedge clk);
                chk($sformatf("%s rst idle", tag), 32'(observed()), 32'(waitv));
                chk($sformatf("%s rst nowrite", tag), 32'(writes), 32'(0));
                return;
            end
            if (noise) begin
                s    = 1'($urandom_range(0, 1));
                load = 1'($urandom_range(0, 1));
                in   = 16'($urandom);
            end
            @(negedge clk);
        end
        s = 1'b0; load = 1'b0;
`ifdef RISC_ILLEGAL_TRAP_EN
        if (!is_legal(instr)) begin
            outs_t trapv;
            trapv = '0;
            trapv.err = 1'b1;
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("%s trap c%0d", tag, i), 32'(observed()), 32'(trapv));
                s = 1'b1; load = 1'b1; in = 16'($urandom);
                @(negedge clk);
            end
            s = 1'b0; load = 1'b0;
            reset_n = 1'b0;
            #1;
            chk($sformatf("%s trap rst", tag), 32'(observed()), 32'(waitv));
            #2 reset_n = 1'b1;
            @(negedge clk);
            chk($sformatf("%s trap idle", tag), 32'(observed()), 32'(waitv));
            return;
        end
`endif
        chk($sformatf("%s done", tag), 32'(observed()), 32'(waitv));
        chk($sformatf("%s imm end", tag), 32'(imm_out), 32'(imm_exp));
        chk($sformatf("%s writes", tag), 32'(writes), 32'(exp_writes));
    endtask

    initial begin
        outs_t waitv;
        waitv = '0;
        waitv.w = 1'b1;
        reset_n = 1'b1; s = 1'b0; load = 1'b0; in = '0;
        #1 reset_n = 1'b0;
        #1;
        chk("reset outs", 32'(observed()), 32'(waitv));
        chk("reset ir", 32'(imm_out), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle outs", 32'(observed()), 32'(waitv));

        // Load without start: IR updates, FSM stays idle.
        in = 16'h00C3; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("load only imm", 32'(imm_out), 32'hFFC3);
        chk("load only idle", 32'(observed()), 32'(waitv));

        run_instr(16'hD0FD, 1'b0, -1, "movimm");
        run_instr(16'hA148, 1'b0, -1, "add");
        run_instr(16'hA900, 1'b0, -1, "cmp");
        run_instr(16'h0000, 1'b0, -1, "illegal");
        run_instr(16'hA148, 1'b1, 2, "add_rst");
        run_instr(16'hB86A, 1'b1, -1, "mvn");
        run_instr(16'hC07B, 1'b1, -1, "movreg");

        for (int n = 0; n < 40; n++) begin
            logic [15:0] instr;
            int          kind, rst_at;
            instr  = 16'($urandom);
            kind   = int'($urandom_range(0, 9));
            rst_at = -1;
            if (kind <= 3) begin
                instr[15:13] = 3'b101;
                if ($urandom_range(0, 4) == 0) rst_at = 1;
            end else if (kind <= 6) begin
                instr[15:11] = 5'b11010;
            end else if (kind == 7) begin
                instr[15:11] = 5'b11000;
            end else if (kind == 8) begin
                instr[15:13] = 3'b110;
                instr[11]    = 1'b1;
            end
            run_instr(instr, 1'b1, rst_at, $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
